// File: rtl/ifetch_queue_if.sv
// Fetch-side bundle: redirect input, in-order instruction memory port and the
// decoded-side head-of-queue handshake.
interface ifetch_queue_if #(
    parameter int WORD      = 64,
    parameter int INSTR_LEN = 32
);
    logic                 pc_src;
    logic [WORD-1:0]      branch_target;
    logic                 imem_req;
    logic [WORD-1:0]      imem_addr;
    logic                 imem_rvalid;
    logic [INSTR_LEN-1:0] imem_rdata;
    logic                 instr_valid;
    logic                 instr_ready;
    logic [INSTR_LEN-1:0] instruction;
    logic [WORD-1:0]      cur_pc;

    modport master (
        output pc_src, branch_target, imem_rvalid, imem_rdata, instr_ready,
        input  imem_req, imem_addr, instr_valid, instruction, cur_pc
    );

    modport slave (
        input  pc_src, branch_target, imem_rvalid, imem_rdata, instr_ready,
        output imem_req, imem_addr, instr_valid, instruction, cur_pc
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: issues sequential fetches under a credit limit,
// pairs in-order memory responses with their PCs, and flushes on redirect.
module ifetch_queue #(
    parameter int              WORD      = 64,
    parameter int              INSTR_LEN = 32,
    parameter int              DEPTH     = 4,
    parameter logic [WORD-1:0] RESET_PC  = '0
) (
    input logic           clk,
    input logic           reset,
    ifetch_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0]     CREDIT  = (CW + 1)'(DEPTH);
    localparam logic [WORD-1:0] PC_STEP = WORD'(4);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    logic [WORD-1:0]      fpc;
    logic [WORD-1:0]      rec_pc   [DEPTH];
    ptr_t                 rec_wr, rec_rd;
    cnt_t                 rec_cnt;
    logic [INSTR_LEN-1:0] q_instr  [DEPTH];
    logic [WORD-1:0]      q_pc     [DEPTH];
    ptr_t                 q_wr, q_rd;
    cnt_t                 q_cnt;
    cnt_t                 drop_cnt;

    cnt_t        in_flight;
    logic [CW:0] credit_used;
    logic        issue, arrive, drop, push, pop, head_valid;

    // Dropped responses still hold an in-flight slot until they arrive, so
    // the credit check counts them alongside recorded requests.
    always_comb begin
        in_flight   = rec_cnt + drop_cnt;
        credit_used = {1'b0, in_flight} + {1'b0, q_cnt};
        issue       = reset && !bus.pc_src && (credit_used < CREDIT);
        arrive      = bus.imem_rvalid && (in_flight != '0);
        drop        = arrive && (drop_cnt != '0);
        push        = arrive && !drop && !bus.pc_src;
        head_valid  = (q_cnt != '0);
        pop         = head_valid && !bus.pc_src && bus.instr_ready;
    end

    assign bus.imem_req    = issue;
    assign bus.imem_addr   = fpc;
    assign bus.instr_valid = head_valid && !bus.pc_src;
    assign bus.instruction = head_valid ? q_instr[q_rd] : '0;
    assign bus.cur_pc      = head_valid ? q_pc[q_rd]    : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fpc      <= RESET_PC;
            rec_wr   <= '0;
            rec_rd   <= '0;
            rec_cnt  <= '0;
            q_wr     <= '0;
            q_rd     <= '0;
            q_cnt    <= '0;
            drop_cnt <= '0;
        end else if (bus.pc_src) begin
            // A response landing this cycle is discarded here, so only the
            // remaining in-flight requests are owed to the drop counter.
            fpc      <= {bus.branch_target[WORD-1:2], 2'b00};
            rec_wr   <= '0;
            rec_rd   <= '0;
            rec_cnt  <= '0;
            q_wr     <= '0;
            q_rd     <= '0;
            q_cnt    <= '0;
            drop_cnt <= in_flight - cnt_t'(arrive);
        end else begin
            if (issue) fpc <= fpc + PC_STEP;
            rec_wr   <= rec_wr + ptr_t'(issue);
            rec_rd   <= rec_rd + ptr_t'(push);
            rec_cnt  <= rec_cnt + cnt_t'(issue) - cnt_t'(push);
            q_wr     <= q_wr + ptr_t'(push);
            q_rd     <= q_rd + ptr_t'(pop);
            q_cnt    <= q_cnt + cnt_t'(push) - cnt_t'(pop);
            drop_cnt <= drop_cnt - cnt_t'(drop);
        end
    end

    // NOTE: storage arrays carry no reset; the counters alone define which
    // entries are live, and outputs are masked to zero while the queue is empty.
    always_ff @(posedge clk) begin
        if (issue) rec_pc[rec_wr] <= fpc;
        if (push) begin
            q_instr[q_wr] <= bus.imem_rdata;
            q_pc[q_wr]    <= rec_pc[rec_rd];
        end
    end
endmodule
